// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types and memory-arbiter state/grant encodings.
// Pure type/constant definitions, no logic.
// Imported by the arbiter and its fairness sub-block.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IMEM_RD = 3'd1,
        DMEM_RD = 3'd2,
        DMEM_WR = 3'd3,
        RESP_I  = 3'd4,
        RESP_D  = 3'd5
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE    = 2'd0,
        GRANT_IMEM    = 2'd1,
        GRANT_DMEM_RD = 2'd2,
        GRANT_DMEM_WR = 2'd3
    } mem_arb_grant_t;

    localparam lc3b_mem_wmask FULL_WORD_MASK = 2'b11;

endpackage

// File: rtl/mem_arb_fairness.sv
// Grant selection for the memory arbiter with imem starvation protection.
// Grant is combinational from requests and the registered starvation count.
// A dmem grant while imem waits bumps the count; at the limit imem is forced.
module mem_arb_fairness
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           imem_read,
    input  logic           dmem_read,
    input  logic           dmem_write,
    input  logic           idle,
    input  logic           grant_i,
    output mem_arb_grant_t grant
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = imem_read && (starve_cnt == CW'(STARVE_LIMIT));

    // Priority select: starved imem, then write, then data read, then imem.
    // A write beats a simultaneous data read so the illegal pair cannot hang.
    always_comb begin
        grant = GRANT_NONE;
        if (idle) begin
            if (starved) begin
                grant = GRANT_IMEM;
            end else if (dmem_write) begin
                grant = GRANT_DMEM_WR;
            end else if (dmem_read) begin
                grant = GRANT_DMEM_RD;
            end else if (imem_read) begin
                grant = GRANT_IMEM;
            end
        end
    end

    // Count consecutive dmem grants taken while imem is waiting; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!imem_read) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            if (grant == GRANT_IMEM) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes one imem read and one dmem read/write onto a single pmem port.
// Latency: request in IDLE at t -> strobe t+1 -> pmem_resp t+1+k -> resp t+2+k.
// Requests wait (held by the CPU) while another transaction is in flight.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          imem_read,
    input  lc3b_word      imem_address,
    output lc3b_word      imem_rdata,
    output logic          imem_resp,

    input  logic          dmem_read,
    input  logic          dmem_write,
    input  lc3b_word      dmem_address,
    input  lc3b_word      dmem_wdata,
    input  lc3b_mem_wmask dmem_byte_enable,
    output lc3b_word      dmem_rdata,
    output logic          dmem_resp,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    output lc3b_mem_wmask pmem_byte_enable,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    mem_arb_state_t state, state_nxt;
    mem_arb_grant_t grant;
    logic           idle;
    logic           grant_i;

    logic           rd_nxt;
    logic           wr_nxt;
    logic           iresp_nxt;
    logic           dresp_nxt;
    lc3b_word       irdata_nxt;
    lc3b_word       drdata_nxt;

    assign idle    = (state == IDLE);
    assign grant_i = (grant != GRANT_NONE);

    mem_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fair (
        .clk        (clk),
        .rst        (rst),
        .imem_read  (imem_read),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .idle       (idle),
        .grant_i    (grant_i),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant out of IDLE, wait for pmem_resp, one response cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                case (grant)
                    GRANT_IMEM:    state_nxt = IMEM_RD;
                    GRANT_DMEM_RD: state_nxt = DMEM_RD;
                    GRANT_DMEM_WR: state_nxt = DMEM_WR;
                    default:       state_nxt = IDLE;
                endcase
            end
            IMEM_RD: if (pmem_resp) state_nxt = RESP_I;
            DMEM_RD: if (pmem_resp) state_nxt = RESP_D;
            DMEM_WR: if (pmem_resp) state_nxt = RESP_D;
            RESP_I:  state_nxt = IDLE;
            RESP_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes, resp and rdata.
    // Strobes stay up until pmem_resp; resp/rdata are set for one cycle only.
    always_comb begin
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        iresp_nxt  = 1'b0;
        dresp_nxt  = 1'b0;
        irdata_nxt = '0;
        drdata_nxt = '0;
        case (state)
            IDLE: begin
                rd_nxt = (grant == GRANT_IMEM) || (grant == GRANT_DMEM_RD);
                wr_nxt = (grant == GRANT_DMEM_WR);
            end
            IMEM_RD: begin
                if (pmem_resp) begin
                    iresp_nxt  = 1'b1;
                    irdata_nxt = pmem_rdata;
                end else begin
                    rd_nxt = 1'b1;
                end
            end
            DMEM_RD: begin
                if (pmem_resp) begin
                    dresp_nxt  = 1'b1;
                    drdata_nxt = pmem_rdata;
                end else begin
                    rd_nxt = 1'b1;
                end
            end
            DMEM_WR: begin
                if (pmem_resp) begin
                    dresp_nxt = 1'b1;
                end else begin
                    wr_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered strobes and responses so pmem/CPU see flop outputs only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            imem_resp  <= 1'b0;
            dmem_resp  <= 1'b0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
        end else begin
            pmem_read  <= rd_nxt;
            pmem_write <= wr_nxt;
            imem_resp  <= iresp_nxt;
            dmem_resp  <= dresp_nxt;
            imem_rdata <= irdata_nxt;
            dmem_rdata <= drdata_nxt;
        end
    end

    // Capture the granted requester's address/data/mask on the grant edge;
    // later input changes cannot disturb the in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= 2'b00;
        end else if (grant_i) begin
            pmem_address     <= (grant == GRANT_IMEM) ? imem_address : dmem_address;
            pmem_wdata       <= (grant == GRANT_DMEM_WR) ? dmem_wdata : '0;
            pmem_byte_enable <= (grant == GRANT_DMEM_WR) ? dmem_byte_enable : FULL_WORD_MASK;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural pmem responder.
// Inputs change 1 time unit after posedge (or at negedge on resp); outputs sampled at negedge.
module tb_mem_arbiter;
    import lc3b_types::*;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int errors;
    int checks;

    // responder controls (written by main block only)
    logic        auto_en;
    logic        fixed_mode;
    logic [15:0] fixed_data;
    int          pmem_wait;
    int          late_req;
    // responder private state
    int          wcnt;
    int          late_done;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_read        (imem_read),
        .imem_address     (imem_address),
        .imem_rdata       (imem_rdata),
        .imem_resp        (imem_resp),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pmem model: answers each strobe after pmem_wait extra cycles, one-cycle resp.
    // Read data is fixed_data or the bitwise complement of the address.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        wcnt       = 0;
        late_done  = 0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end else if (late_req != late_done) begin
                pmem_resp  = 1'b1;
                pmem_rdata = 16'hDEAD;
                late_done  = late_req;
            end else if (auto_en && (pmem_read || pmem_write)) begin
                if (wcnt >= pmem_wait) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = fixed_mode ? fixed_data : ~pmem_address;
                    wcnt       = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    function automatic logic [69:0] all_outs();
        return {imem_resp, dmem_resp, pmem_read, pmem_write, imem_rdata, dmem_rdata,
                pmem_address, pmem_wdata, pmem_byte_enable};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== 70'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_imem_read();
        int strobe_cyc = 0;
        int addr_bad   = 0;
        int iresp_n    = 0;
        int dresp_n    = 0;
        int lat        = -1;
        logic [15:0] got = '0;
        auto_en = 1'b1; fixed_mode = 1'b1; fixed_data = 16'hABCD; pmem_wait = 2;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h1000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (pmem_read) begin
                strobe_cyc++;
                if (pmem_address !== 16'h1000) addr_bad++;
            end
            if (dmem_resp) dresp_n++;
            if (imem_resp) begin
                iresp_n++;
                got = imem_rdata;
                if (lat < 0) lat = c;
                imem_read = 1'b0;
            end
        end
        checks++;
        if (strobe_cyc !== 3) begin errors++; $display("FAIL imem_strobe_cycles: got %0d expected 3", strobe_cyc); end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("FAIL imem_pmem_address: got %0d bad cycles expected 0", addr_bad); end
        checks++;
        if (iresp_n !== 1) begin errors++; $display("FAIL imem_resp_count: got %0d expected 1", iresp_n); end
        checks++;
        if (got !== 16'hABCD) begin errors++; $display("FAIL imem_rdata: got %h expected abcd", got); end
        checks++;
        if (dresp_n !== 0) begin errors++; $display("FAIL imem_no_dmem_resp: got %0d expected 0", dresp_n); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL imem_latency: got %0d expected 5", lat); end
        checks++;
        if (imem_rdata !== 16'h0) begin errors++; $display("FAIL imem_rdata_after_pulse: got %h expected 0", imem_rdata); end
    endtask

    task automatic test_arbitration();
        logic [15:0] order[$];
        logic        prev = 1'b0;
        logic        st;
        int          both = 0;
        int          ip = 0;
        int          dp = 0;
        logic [15:0] ir = '0;
        logic [15:0] dr = '0;
        logic [15:0] o0;
        logic [15:0] o1;
        auto_en = 1'b1; fixed_mode = 1'b0; pmem_wait = 0;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h2000;
        dmem_read = 1'b1; dmem_address = 16'h3000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            st = pmem_read | pmem_write;
            if (st && !prev) order.push_back(pmem_address);
            prev = st;
            if (imem_resp && dmem_resp) both++;
            if (dmem_resp) begin dp++; dr = dmem_rdata; dmem_read = 1'b0; end
            if (imem_resp) begin ip++; ir = imem_rdata; imem_read = 1'b0; end
        end
        o0 = (order.size() > 0) ? order[0] : 16'hxxxx;
        o1 = (order.size() > 1) ? order[1] : 16'hxxxx;
        checks++;
        if (order.size() !== 2) begin errors++; $display("FAIL arb_grant_count: got %0d expected 2", order.size()); end
        checks++;
        if (o0 !== 16'h3000) begin errors++; $display("FAIL arb_first_grant: got %h expected 3000", o0); end
        checks++;
        if (o1 !== 16'h2000) begin errors++; $display("FAIL arb_second_grant: got %h expected 2000", o1); end
        checks++;
        if (both !== 0) begin errors++; $display("FAIL arb_simultaneous_resp: got %0d expected 0", both); end
        checks++;
        if (dp !== 1 || ip !== 1) begin errors++; $display("FAIL arb_resp_pulses: got d=%0d i=%0d expected 1 1", dp, ip); end
        checks++;
        if (dr !== 16'hCFFF) begin errors++; $display("FAIL arb_dmem_rdata: got %h expected cfff", dr); end
        checks++;
        if (ir !== 16'hDFFF) begin errors++; $display("FAIL arb_imem_rdata: got %h expected dfff", ir); end
    endtask

    task automatic test_write();
        int wcyc = 0;
        int bad  = 0;
        int dp   = 0;
        logic [15:0] dr = 16'hFFFF;
        auto_en = 1'b1; pmem_wait = 1;
        @(posedge clk); #1;
        dmem_write = 1'b1; dmem_address = 16'h0040; dmem_wdata = 16'h1234; dmem_byte_enable = 2'b01;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pmem_write) begin
                wcyc++;
                if (pmem_wdata !== 16'h1234 || pmem_byte_enable !== 2'b01 ||
                    pmem_address !== 16'h0040 || pmem_read !== 1'b0) bad++;
                dmem_wdata = 16'hFFFF; dmem_byte_enable = 2'b11; dmem_address = 16'hFFFF;
            end
            if (dmem_resp) begin dp++; dr = dmem_rdata; dmem_write = 1'b0; end
        end
        checks++;
        if (wcyc !== 2) begin errors++; $display("FAIL write_strobe_cycles: got %0d expected 2", wcyc); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL write_latched_fields: got %0d bad cycles expected 0", bad); end
        checks++;
        if (dp !== 1) begin errors++; $display("FAIL write_resp_count: got %0d expected 1", dp); end
        checks++;
        if (dr !== 16'h0000) begin errors++; $display("FAIL write_dmem_rdata: got %h expected 0", dr); end
    endtask

    task automatic test_starvation();
        logic [15:0] order[$];
        logic [15:0] exp_ord [5] = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0100};
        logic        prev = 1'b0;
        logic        st;
        int          bad = 0;
        int          dp = 0;
        int          ip = 0;
        int          cnt_at = -1;
        auto_en = 1'b1; fixed_mode = 1'b0; pmem_wait = 0;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h0100;
        dmem_read = 1'b1; dmem_address = 16'h0200;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            st = pmem_read | pmem_write;
            if (st && !prev) begin
                order.push_back(pmem_address);
                if (pmem_address == 16'h0100) cnt_at = int'(dut.u_fair.starve_cnt);
            end
            prev = st;
            if (dmem_resp) dp++;
            if (imem_resp) begin ip++; imem_read = 1'b0; dmem_read = 1'b0; end
        end
        for (int i = 0; i < 5; i++) begin
            if (i >= order.size() || order[i] !== exp_ord[i]) bad++;
        end
        checks++;
        if (bad !== 0 || order.size() !== 5) begin
            errors++;
            $display("FAIL starve_grant_order: got %0d grants with %0d wrong expected 4 dmem then imem", order.size(), bad);
        end
        checks++;
        if (dp !== 4) begin errors++; $display("FAIL starve_dmem_resp: got %0d expected 4", dp); end
        checks++;
        if (ip !== 1) begin errors++; $display("FAIL starve_imem_resp: got %0d expected 1", ip); end
        checks++;
        if (cnt_at !== 0) begin errors++; $display("FAIL starve_cnt_cleared: got %0d expected 0", cnt_at); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        int stray = 0;
        int ip = 0;
        logic [15:0] ir = '0;
        auto_en = 1'b0;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h0500;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        checks++;
        if (seen !== 1) begin errors++; $display("FAIL rst_strobe_before: got %0d expected 1", seen); end
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 70'd0) begin errors++; $display("FAIL rst_async_outputs: got %h expected 0", all_outs()); end
        @(posedge clk); #1;
        rst = 1'b0;
        imem_read = 1'b0;
        late_req++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (imem_resp || dmem_resp || pmem_read || pmem_write) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL rst_late_resp_ignored: got %0d active cycles expected 0", stray); end
        auto_en = 1'b1; fixed_mode = 1'b0; pmem_wait = 0;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h0600;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (imem_resp) begin ip++; ir = imem_rdata; imem_read = 1'b0; end
        end
        checks++;
        if (ip !== 1 || ir !== 16'hF9FF) begin
            errors++;
            $display("FAIL rst_recover_read: got resp=%0d rdata=%h expected 1 f9ff", ip, ir);
        end
    endtask

    task automatic test_read_write_both();
        int rdseen = 0;
        int wcyc = 0;
        int bad = 0;
        int dp = 0;
        auto_en = 1'b1; pmem_wait = 1;
        @(posedge clk); #1;
        dmem_read = 1'b1; dmem_write = 1'b1;
        dmem_address = 16'h0080; dmem_wdata = 16'h5555; dmem_byte_enable = 2'b10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pmem_read) rdseen++;
            if (pmem_write) begin
                wcyc++;
                if (pmem_wdata !== 16'h5555 || pmem_byte_enable !== 2'b10 || pmem_address !== 16'h0080) bad++;
            end
            if (dmem_resp) begin dp++; dmem_read = 1'b0; dmem_write = 1'b0; end
        end
        checks++;
        if (rdseen !== 0 || wcyc !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL rw_both_write_issued: got rd=%0d wr=%0d bad=%0d expected 0 2 0", rdseen, wcyc, bad);
        end
        checks++;
        if (dp !== 1) begin errors++; $display("FAIL rw_both_resp: got %0d expected 1", dp); end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL rw_both_idle: got %0d expected %0d", dut.state, IDLE); end
    endtask

    initial begin
        errors = 0; checks = 0;
        auto_en = 1'b0; fixed_mode = 1'b0; fixed_data = '0; pmem_wait = 0; late_req = 0;
        rst = 1'b1;
        imem_read = 1'b0; imem_address = '0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0; dmem_wdata = '0; dmem_byte_enable = '0;

        test_reset();
        test_imem_read();
        test_arbitration();
        test_write();
        test_starvation();
        test_reset_midflight();
        test_read_write_both();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
